// File: rtl/fma16_pkg.sv
// Shared types and constants for the fp16 FMA normalize/round stage.
// Holds rounding modes, flag positions and the stage-1 pipeline record.
package fma16_pkg;

  typedef enum logic [1:0] {
    RZ  = 2'b00,
    RNE = 2'b01,
    RM  = 2'b10,
    RP  = 2'b11
  } roundmode_t;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int          BIAS   = 15;
  localparam int          EMAX   = 30;
  localparam logic [14:0] MAXFIN = 15'h7BFF;
  localparam logic [14:0] INF    = 15'h7C00;

  // Normalized sum as it crosses from the normalize stage to the round stage.
  typedef struct packed {
    logic [10:0] mant;
    logic        guard;
    logic        sticky;
    logic [8:0]  exp;
    logic        sign;
    roundmode_t  rm;
    logic        zero;
    logic        special;
    logic [15:0] special_res;
    logic        special_nv;
  } norm_t;

  function automatic logic round_inc(input roundmode_t rm, input logic sign,
                                     input logic lsb, input logic guard,
                                     input logic sticky);
    logic inc;
    case (rm)
      RNE:     inc = guard & (sticky | lsb);
      RP:      inc = ~sign & (guard | sticky);
      RM:      inc = sign & (guard | sticky);
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/lzc34.sv
// Combinational leading-zero counter for the 34-bit sum magnitude.
// An all-zero input reports 34.
module lzc34 (
  input  logic [33:0] a_i,
  output logic [5:0]  cnt_o
);

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_o and no latch is inferred.
    cnt_o = 6'd34;
    for (int i = 0; i < 34; i++) begin
      if (a_i[i]) cnt_o = 6'(33 - i);
    end
  end

endmodule

// File: rtl/fma16_normround.sv
// Final fp16 FMA stage: normalize the unnormalized sum, round to binary16,
// handle overflow/subnormal/zero/special cases, behind a 2-deep valid/ready pipe.
module fma16_normround
  import fma16_pkg::*;
#(
  parameter bit FLUSH_SUBNORM = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [33:0] Sm,
  input  logic [6:0]  Se,
  input  logic        Ss,
  input  logic        ASticky,
  input  logic [1:0]  roundmode,
  input  logic        special,
  input  logic [15:0] special_res,
  input  logic        special_nv,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [3:0]  flags
);

  logic        v1_q, v2_q;
  logic        adv1, adv2;
  norm_t       s1_d, s1_q;
  logic [15:0] result_d, result_q;
  logic [3:0]  flags_d, flags_q;

  assign adv2      = ~v2_q | out_ready;
  assign adv1      = ~v1_q | adv2;
  assign in_ready  = adv1;
  assign out_valid = v2_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // ---------------- Stage 1: normalize ----------------
  logic [5:0]        lzc;
  logic signed [8:0] se_x, e_norm, sub_shift, sub_neg;
  logic              is_norm;
  logic [5:0]        rsh;
  logic [69:0]       rwide;
  logic [33:0]       shifted;
  logic              lost;

  lzc34 u_lzc (
    .a_i   (Sm),
    .cnt_o (lzc)
  );

  always_comb begin
    se_x      = {{2{Se[6]}}, Se};
    e_norm    = se_x + 9'sd12 - $signed({3'b000, lzc});
    sub_shift = se_x + 9'sd11;
    sub_neg   = -sub_shift;
    is_norm   = e_norm > 9'sd0;
    shifted   = Sm;
    lost      = 1'b0;
    rsh       = '0;
    rwide     = '0;
    if (is_norm) begin
      shifted = Sm << lzc;
    end else if (!sub_shift[8]) begin
      shifted = Sm << sub_shift[5:0];
    end else begin
      // Right shift is capped at 35: beyond that every bit is already sticky.
      rsh     = (sub_neg > 9'sd35) ? 6'd35 : sub_neg[5:0];
      rwide   = {Sm, 36'b0} >> rsh;
      shifted = rwide[69:36];
      lost    = |rwide[35:0];
    end

    s1_d.mant        = shifted[33:23];
    s1_d.guard       = shifted[22];
    s1_d.sticky      = (|shifted[21:0]) | ASticky | lost;
    s1_d.exp         = is_norm ? e_norm : 9'sd1;
    s1_d.sign        = Ss;
    s1_d.rm          = roundmode_t'(roundmode);
    s1_d.zero        = (Sm == '0) & ~ASticky;
    s1_d.special     = special;
    s1_d.special_res = special_res;
    s1_d.special_nv  = special_nv;
  end

  // ---------------- Stage 2: round ----------------
  logic        inc, nx, uf;
  logic [11:0] m_sum;
  logic [10:0] m_rnd;
  logic [8:0]  e_rnd, e_enc;

  always_comb begin
    inc   = round_inc(s1_q.rm, s1_q.sign, s1_q.mant[0], s1_q.guard, s1_q.sticky);
    m_sum = {1'b0, s1_q.mant} + 12'(inc);
    if (m_sum[11]) begin
      m_rnd = m_sum[11:1];
      e_rnd = s1_q.exp + 9'd1;
    end else begin
      m_rnd = m_sum[10:0];
      e_rnd = s1_q.exp;
    end
    // A subnormal that carries into bit 10 picks up exponent 1 here.
    e_enc = m_rnd[10] ? e_rnd : 9'd0;
    nx    = s1_q.guard | s1_q.sticky;
    uf    = nx & (e_enc == 9'd0);

    result_d = {s1_q.sign, e_enc[4:0], m_rnd[9:0]};
    flags_d  = '0;
    flags_d[FLAG_UF] = uf;
    flags_d[FLAG_NX] = nx;

    if (s1_q.special) begin
      result_d = s1_q.special_res;
      flags_d  = '0;
      flags_d[FLAG_NV] = s1_q.special_nv;
    end else if (s1_q.zero) begin
      result_d = {(s1_q.rm == RM), 15'h0000};
      flags_d  = '0;
    end else if (e_enc > 9'(EMAX)) begin
      case (s1_q.rm)
        RNE:     result_d = {s1_q.sign, INF};
        RZ:      result_d = {s1_q.sign, MAXFIN};
        RP:      result_d = s1_q.sign ? {1'b1, MAXFIN} : {1'b0, INF};
        default: result_d = s1_q.sign ? {1'b1, INF} : {1'b0, MAXFIN};
      endcase
      flags_d = '0;
      flags_d[FLAG_OF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end else if (FLUSH_SUBNORM && (e_enc == 9'd0) && (m_rnd[9:0] != '0)) begin
      result_d = {s1_q.sign, 15'h0000};
      flags_d  = '0;
      flags_d[FLAG_UF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end
  end

  // ---------------- Pipeline registers ----------------
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          result_q <= result_d;
          flags_q  <= flags_d;
        end
      end
    end
  end

  // NOTE: the stage-1 payload has no reset; v1_q qualifies it, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) s1_q <= s1_d;
  end

endmodule
